// File: rtl/fft16_pkg.sv
// fft16_pkg: shared constants and the 8-entry cos/-sin twiddle table for the 16-point FFT
package fft16_pkg;
  localparam int N16 = 16;
  localparam int TW_SCALE = 127;
  localparam logic signed [7:0] COS_T [8] = '{8'sd127, 8'sd117, 8'sd90, 8'sd49, 8'sd0, -8'sd49, -8'sd90, -8'sd117};
  localparam logic signed [7:0] MSIN_T [8] = '{8'sd0, -8'sd49, -8'sd90, -8'sd117, -8'sd127, -8'sd117, -8'sd90, -8'sd49};
  function automatic logic [15:0] tw_lookup(input logic [2:0] k);
    return {COS_T[k], MSIN_T[k]};
  endfunction
endpackage

// File: rtl/tw_rom8.sv
// tw_rom8: combinational first-half twiddle ROM, k -> round(127cos), -round(127sin)
// ports: k index 0..7; c, s signed W-bit coefficients
module tw_rom8
  import fft16_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]          k,
  output logic signed [W-1:0] c,
  output logic signed [W-1:0] s
);
  logic signed [7:0] c8, s8;
  assign {c8, s8} = tw_lookup(k);
  assign c = W'(c8);
  assign s = W'(s8);
endmodule

// File: rtl/twiddle_seq.sv
// twiddle_seq: 2-stage twiddle feeder producing c, c+s, c-s aligned with the delayed sample
// ports: clk, reset (async active-low), clr (sync frame restart);
//        in_valid/in_ready/x_in/y_in sample input; out_valid/out_ready handshake;
//        x_out/y_out delayed sample, c_out, cps_out, cms_out twiddle terms, k_out index, last_out
module twiddle_seq
  import fft16_pkg::*;
#(
  parameter int W     = 8,
  parameter int W1    = 9,
  parameter int LOGN  = 4,
  parameter int STAGE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  x_out,
  output logic signed [W-1:0]  y_out,
  output logic signed [W-1:0]  c_out,
  output logic signed [W1-1:0] cps_out,
  output logic signed [W1-1:0] cms_out,
  output logic [LOGN-1:0]      k_out,
  output logic                 last_out
);
  if (LOGN != 4 || (1 << LOGN) != N16) begin : g_bad
    $error("twiddle_seq supports only LOGN=4");
  end
  logic                up, en, xfer, v1, l1;
  logic [LOGN-1:0]     n, kn, k1;
  logic signed [W-1:0] x1, y1, c1, s1, c0, s0, cn, sn;
  assign en = !(out_valid && !out_ready);
  // up holds in_ready low until the first edge after reset release
  assign in_ready = en && up;
  assign xfer = in_valid && in_ready;
  // (n mod (N>>STAGE)) << STAGE is n << STAGE truncated to LOGN bits
  assign kn = n << STAGE;
  tw_rom8 #(.W(W)) u_rom (.k(kn[2:0]), .c(c0), .s(s0));
  // second half of the circle: W16^(k+8) = -W16^k
  assign cn = k1[LOGN-1] ? -c1 : c1;
  assign sn = k1[LOGN-1] ? -s1 : s1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up <= 1'b0;
      n <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
      k1 <= '0;
      x1 <= '0;
      y1 <= '0;
      c1 <= '0;
      s1 <= '0;
      out_valid <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      c_out <= '0;
      cps_out <= '0;
      cms_out <= '0;
      k_out <= '0;
      last_out <= 1'b0;
    end else begin
      up <= 1'b1;
      if (clr) begin
        n <= '0;
        v1 <= 1'b0;
        out_valid <= 1'b0;
      end else if (en) begin
        if (xfer) n <= n + 1'b1;
        v1 <= xfer;
        out_valid <= v1;
      end
      // data only moves with a valid sample so idle outputs keep their last values
      if (en && xfer) begin
        x1 <= x_in;
        y1 <= y_in;
        k1 <= kn;
        l1 <= n == LOGN'(N16 - 1);
        c1 <= c0;
        s1 <= s0;
      end
      if (en && v1) begin
        x_out <= x1;
        y_out <= y1;
        k_out <= k1;
        last_out <= l1;
        c_out <= cn;
        cps_out <= W1'(cn) + W1'(sn);
        cms_out <= W1'(cn) - W1'(sn);
      end
    end
  end
endmodule

// File: tb/tb_twiddle_seq.sv
// tb_twiddle_seq: scoreboard bench for twiddle_seq at STAGE 0 and STAGE 2
module tb_twiddle_seq;
  typedef struct {
    int x, y, k, c, cps, cms, last, cyc;
    bit lat;
  } exp_t;
  logic clk = 0, reset, clr, in_valid, out_ready;
  logic signed [7:0] x_in, y_in;
  logic ir [2], ov [2], lo [2];
  logic signed [7:0] xo [2], yo [2], co [2];
  logic signed [8:0] cpso [2], cmso [2];
  logic [3:0] ko [2];
  exp_t q [2][$];
  int total = 0, pass = 0, cyc = 0, nm = 0, xc = 0;
  logic [46:0] snap [2];
  bit pst [2];
  always #5 clk = ~clk;
  twiddle_seq #(.STAGE(0)) u0 (.clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(ir[0]),
    .x_in(x_in), .y_in(y_in), .out_valid(ov[0]), .out_ready(out_ready), .x_out(xo[0]), .y_out(yo[0]),
    .c_out(co[0]), .cps_out(cpso[0]), .cms_out(cmso[0]), .k_out(ko[0]), .last_out(lo[0]));
  twiddle_seq #(.STAGE(2)) u2 (.clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(ir[1]),
    .x_in(x_in), .y_in(y_in), .out_valid(ov[1]), .out_ready(out_ready), .x_out(xo[1]), .y_out(yo[1]),
    .c_out(co[1]), .cps_out(cpso[1]), .cms_out(cmso[1]), .k_out(ko[1]), .last_out(lo[1]));
  task automatic chk(input string nm_, input int act, input int req);
    total++;
    if (act == req) pass++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm_, act, req, $time);
  endtask
  function automatic int rnd(input real r);
    return r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction
  function automatic exp_t mk(input int kk, input int x, input int y, input int last, input int cy, input bit lt);
    real a;
    int c, s;
    a = 3.14159265358979 * kk / 8.0;
    c = rnd(127.0 * $cos(a));
    s = -rnd(127.0 * $sin(a));
    mk.x = x; mk.y = y; mk.k = kk; mk.c = c; mk.cps = c + s; mk.cms = c - s;
    mk.last = last; mk.cyc = cy; mk.lat = lt;
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin q[i].delete(); pst[i] = 0; end
      nm = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [46:0] now;
        exp_t e;
        now = {xo[i], yo[i], co[i], cpso[i], cmso[i], ko[i], lo[i]};
        if (q[i].size() > 0 && q[i][0].lat) begin
          if (cyc - q[i][0].cyc == 1) chk($sformatf("u%0d latency early", i * 2), int'(ov[i]), 0);
          if (cyc - q[i][0].cyc == 2) chk($sformatf("u%0d latency valid", i * 2), int'(ov[i]), 1);
        end
        if (ov[i] && out_ready) begin
          if (q[i].size() == 0) chk($sformatf("u%0d spurious output", i * 2), 1, 0);
          else begin
            e = q[i].pop_front();
            chk($sformatf("u%0d x_out", i * 2), int'(xo[i]), e.x);
            chk($sformatf("u%0d y_out", i * 2), int'(yo[i]), e.y);
            chk($sformatf("u%0d k_out", i * 2), int'(ko[i]), e.k);
            chk($sformatf("u%0d c_out k=%0d", i * 2, e.k), int'(co[i]), e.c);
            chk($sformatf("u%0d cps_out k=%0d", i * 2, e.k), int'(cpso[i]), e.cps);
            chk($sformatf("u%0d cms_out k=%0d", i * 2, e.k), int'(cmso[i]), e.cms);
            chk($sformatf("u%0d last_out", i * 2), int'(lo[i]), e.last);
          end
        end
        if (ov[i] && !out_ready) begin
          chk($sformatf("u%0d in_ready in stall", i * 2), int'(ir[i]), 0);
          if (pst[i]) chk($sformatf("u%0d outputs change in stall", i * 2), int'(now != snap[i]), 0);
          pst[i] = 1;
          snap[i] = now;
        end else pst[i] = 0;
      end
      if (clr) begin
        for (int i = 0; i < 2; i++) q[i].delete();
        nm = 0;
      end else if (in_valid && ir[0]) begin
        for (int i = 0; i < 2; i++)
          q[i].push_back(mk(((nm % (16 >> (i * 2))) << (i * 2)) & 15, int'(x_in), int'(y_in),
                            int'(nm == 15), cyc, q[i].size() == 0));
        nm = (nm + 1) % 16;
      end
    end
  end
  task automatic stream(input int cnt, input int pv, input int pr, input bit rxy);
    int got = 0, guard = 0;
    bit acc = 1;
    while (got < cnt && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      if (pr >= 0) out_ready = ($urandom_range(99) < pr);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(99) < pv);
        x_in = rxy ? 8'($urandom) : 8'(xc);
        y_in = rxy ? 8'($urandom) : 8'(-xc);
      end
      @(negedge clk);
      acc = in_valid && ir[0] && !clr;
      if (acc) begin got++; xc++; end
    end
    if (guard >= 5000) chk("stream timeout", got, cnt);
    @(posedge clk); #1 in_valid = 0;
  endtask
  task automatic drain();
    int g = 0;
    out_ready = 1;
    while ((q[0].size() > 0 || q[1].size() > 0) && g < 300) begin @(posedge clk); g++; end
    #1;
    chk("drain q0 empty", q[0].size(), 0);
    chk("drain q2 empty", q[1].size(), 0);
  endtask
  initial begin
    reset = 0; clr = 0; in_valid = 1; out_ready = 1; x_in = 8'sd5; y_in = -8'sd5;
    repeat (3) @(negedge clk)
      for (int i = 0; i < 2; i++) begin
        chk("reset out_valid", int'(ov[i]), 0);
        chk("reset x_out", int'(xo[i]), 0);
        chk("reset c_out", int'(co[i]), 0);
        chk("reset cps_out", int'(cpso[i]), 0);
        chk("reset k_out", int'(ko[i]), 0);
        chk("reset last_out", int'(lo[i]), 0);
      end
    @(posedge clk); #1 reset = 1; in_valid = 0;
    @(posedge clk); #1 chk("in_ready after reset", int'(ir[0]), 1);
    xc = 0;
    stream(16, 100, 100, 0);
    drain();
    xc = 0;
    fork
      stream(16, 100, -1, 0);
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    xc = 0;
    stream(20, 100, 100, 0);
    @(posedge clk); #1 clr = 1; in_valid = 1; x_in = 8'sd99; y_in = 8'sd99;
    @(posedge clk); #1 clr = 0; in_valid = 0;
    stream(3, 100, 100, 0);
    drain();
    stream(5, 100, 100, 0);
    reset = 0;
    #1 chk("async reset out_valid u0", int'(ov[0]), 0);
    chk("async reset out_valid u2", int'(ov[1]), 0);
    @(posedge clk); #1 reset = 1;
    stream(4, 100, 100, 0);
    drain();
    stream(150, 60, 60, 1);
    drain();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
Upstream feeder for the 3-multiplier complex multiplier in a 16-point radix-2 FFT stage. It accepts a stream of complex samples (x + jy) and tracks the sample index within the frame. For each sample it emits the matching twiddle W16^k as c, c+s and c−s, pipelined and aligned with the delayed sample. The multiplier computes (x + jy)(c + js), so the block drives s = −sin.

Parameters:
W, 8, sample and twiddle coefficient width (signed)
W1, 9, width of cps_out/cms_out (W+1)
LOGN, 4, log2 of FFT length; only 4 is supported, and any other value is an elaboration error
STAGE, 0, FFT stage number 0..LOGN−1; sets the twiddle stride

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
clr  in  1  synchronous frame restart: sample counter to 0, pipeline valids cleared
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
x_in  in  W  real part of sample, signed
y_in  in  W  imaginary part of sample, signed
out_valid  out  1  outputs valid
out_ready  in  1  downstream accepts outputs
x_out  out  W  delayed real part
y_out  out  W  delayed imaginary part
c_out  out  W  round(127·cos θ)
cps_out  out  W1  c+s, sign-extended
cms_out  out  W1  c−s, sign-extended
k_out  out  LOGN  twiddle index, for debug and verification
last_out  out  1  sample is index N−1 of its frame

Behaviour:
- Reset (reset=0, asynchronous): all registers 0. in_ready goes 1 once reset is released. out_valid=0, all data outputs 0, counter n=0.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Pipeline: two register stages, S1 and S2. Latency from input transfer to out_valid is 2 cycles when no stall.
- Stall: global enable en = !(out_valid && !out_ready). in_ready = en.
  - When en=0, S1 and S2 hold.
  - Bubbles propagate: the valid bit moves even when in_valid=0.
- Counter n (LOGN bits) increments on each input transfer and wraps from 15 to 0. Frame bookkeeping is implicit.
- Twiddle index: k = (n mod (N>>STAGE)) << STAGE, truncated to LOGN bits.
- S1 registers: x, y, k, last (= n==N−1), valid, and the ROM lookup of k[2:0] giving (c0, s0).
- ROM, indexed by k[2:0], as (c, s):
  - 0: (127, 0)
  - 1: (117, −49)
  - 2: (90, −90)
  - 3: (49, −117)
  - 4: (0, −127)
  - 5: (−49, −117)
  - 6: (−90, −90)
  - 7: (−117, −49)
- S2 registers:
  - If k[3]=1, c=−c0 and s=−s0; otherwise c=c0 and s=s0.
  - cps = sxt(c)+sxt(s) and cms = sxt(c)−sxt(s), computed in W1 bits. The result never overflows because |c|,|s| ≤ 127.
  - x, y, k and last pass through.
- Unity twiddle is 127/128. The downstream scaling by 2^−7 therefore gives a known gain of 127/128; this is accepted and documented.
- clr:
  - Takes priority over input transfer in the same cycle; that sample is dropped.
  - n returns to 0 and S1/S2 valids clear on the next edge.
  - Data registers may keep stale values.
- Reset mid-frame: the in-flight samples are lost and n restarts at 0.
- When out_valid=0, the data outputs hold their last values; consumers must qualify them with out_valid.

Decomposition:
- Package fft16_pkg holds:
  - constants N16=16 and TW_SCALE=127;
  - the 8-entry cos/−sin ROM as localparam arrays;
  - a function tw_lookup(k) returning {c, s}.
- Natural sub-module: tw_rom8, a combinational 8-entry case ROM instantiated in S1. Everything else stays in twiddle_seq.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with in_valid=1 → out_valid=0, all outputs 0; in_ready=1 one cycle after release.
2. STAGE=0, stream 16 samples x=n, y=−n back-to-back, out_ready=1:
   - first output 2 cycles after the first transfer;
   - k_out runs 0..15;
   - k=2 gives c=90, cps=0, cms=180;
   - k=4 gives c=0, cps=−127, cms=127;
   - k=12 gives c=0, cps=127, cms=−127;
   - last_out=1 only at k=15.
3. STAGE=2 with 16 samples → k_out pattern 0,4,8,12 repeated four times; k=8 gives c=−127, cps=−127, cms=−127.
4. Backpressure:
   - drop out_ready for 3 cycles mid-stream → in_ready=0 and outputs held stable over those cycles;
   - no sample lost or duplicated; the x_out sequence is still 0..15.
5. Counter wrap: stream 20 samples → the 17th sample has k_out=0 and x_out=16; then assert clr together with in_valid → that sample is dropped and the next accepted sample has k_out=0.
6. Reset mid-frame: after 5 transfers, pulse reset low for 1 cycle → out_valid=0 immediately (asynchronous); the next sample gets k_out=0.
